// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN stack sequencer: command opcodes, FSM state codes,
// depth counter width and the error-flag bundle.
package rpn_pkg;

  // Opcode values follow the pushbutton index on the front panel.
  typedef enum logic [1:0] {
    OP_MULT = 2'd0,
    OP_ADD  = 2'd1,
    OP_POP  = 2'd2,
    OP_PUSH = 2'd3
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;

  localparam int DEPTH_W = 4;

  typedef struct packed {
    logic under;
    logic full;
    logic ovf;
  } err_t;

endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// Command handshake between the pushbutton front end (master) and the stack sequencer (slave).
interface rpn_stack_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/rpn_seq_mult.sv
// Iterative signed shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
// The MSB partial product carries negative weight, so it is subtracted instead of added.
module rpn_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               run_q,    run_d;
  logic [2*WIDTH-1:0] pp;
  logic               last;

  assign last    = (cnt_q == CNT_W'(WIDTH - 1));
  // done marks the cycle whose closing edge adds the final partial product.
  assign done    = run_q & last;
  assign product = acc_q;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    pp       = mplier_q[0] ? mcand_q : '0;

    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{a[WIDTH-1]}}, a};
      mplier_d = b;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = last ? (acc_q - pp) : (acc_q + pp);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last) run_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN calculator stack sequencer: takes one PUSH/POP/ADD/MULT command at a time and
// drives a DEPTH-entry signed register stack, reporting top-of-stack, depth and error flags.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  rpn_stack_ctrl_if.slave           cmd,
  output logic signed [WIDTH-1:0]   dout,
  output logic                      dval,
  output logic [DEPTH_W-1:0]        depth,
  output logic                      busy,
  output logic                      err_under,
  output logic                      err_full,
  output logic                      err_ovf
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]         state_q, state_d;
  op_e                op_q,    op_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  err_t               err_q,   err_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [WIDTH-1:0]   dout_q,  dout_d;
  logic               dval_q,  dval_d;
  logic [WIDTH-1:0]   stack_q [DEPTH];
  logic [WIDTH-1:0]   stack_d [DEPTH];

  logic [IDX_W-1:0]   tos_idx, nos_idx, push_idx;
  logic [WIDTH-1:0]   tos, nos;
  logic [WIDTH:0]     sum_full;
  logic               add_ovf, mul_ovf;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               has_two;

  // Indices wrap harmlessly when depth is too small; those cases are rejected before use.
  assign tos_idx  = IDX_W'(depth_q - 1'b1);
  assign nos_idx  = IDX_W'(depth_q - DEPTH_W'(2));
  assign push_idx = IDX_W'(depth_q);
  assign tos      = stack_q[tos_idx];
  assign nos      = stack_q[nos_idx];
  assign has_two  = (depth_q >= DEPTH_W'(2));

  assign sum_full = {nos[WIDTH-1], nos} + {tos[WIDTH-1], tos};
  assign add_ovf  = sum_full[WIDTH] ^ sum_full[WIDTH-1];
  // The product fits only if its upper WIDTH+1 bits are a pure sign extension.
  assign mul_ovf  = (|mul_product[2*WIDTH-1:WIDTH-1]) & ~(&mul_product[2*WIDTH-1:WIDTH-1]);

  assign alu_res  = (op_q == OP_ADD) ? sum_full[WIDTH-1:0] : mul_product[WIDTH-1:0];
  assign alu_ovf  = (op_q == OP_ADD) ? add_ovf : mul_ovf;

  rpn_seq_mult #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk     (clk),
    .rst_n   (reset),
    .start   (mul_start),
    .a       (nos),
    .b       (tos),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    err_d     = err_q;
    depth_d   = depth_q;
    dout_d    = dout_q;
    dval_d    = dval_q;
    stack_d   = stack_q;
    mul_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d   = op_e'(cmd.cmd_op);
          data_d = cmd.cmd_data;
          err_d  = '0;
          // A MULT short of operands skips the multiplier and is rejected in EXEC.
          if (op_e'(cmd.cmd_op) == OP_MULT && has_two) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_MUL: begin
        if (mul_done) state_d = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_IDLE;
        case (op_q)
          OP_PUSH: begin
            if (depth_q < DEPTH_W'(DEPTH)) begin
              stack_d[push_idx] = data_q;
              depth_d           = depth_q + 1'b1;
            end else begin
              err_d.full = 1'b1;
            end
          end
          OP_POP: begin
            if (depth_q != '0) depth_d = depth_q - 1'b1;
            else               err_d.under = 1'b1;
          end
          default: begin
            if (has_two) begin
              stack_d[nos_idx] = alu_res;
              depth_d          = depth_q - 1'b1;
              err_d.ovf        = alu_ovf;
            end else begin
              err_d.under = 1'b1;
            end
          end
        endcase
        dval_d = (depth_d != '0);
        dout_d = (depth_d != '0) ? stack_d[IDX_W'(depth_d - 1'b1)] : '0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      data_q  <= '0;
      err_q   <= '0;
      depth_q <= '0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      // NOTE: the stack is a small flop array, so clearing it on reset is cheap and keeps
      // every entry defined; a RAM-backed stack would not be reset this way.
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      err_q   <= err_d;
      depth_q <= depth_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign dout          = dout_q;
  assign dval          = dval_q;
  assign depth         = depth_q;
  assign err_under     = err_q.under;
  assign err_full      = err_q.full;
  assign err_ovf       = err_q.ovf;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Scoreboard bench for rpn_stack_ctrl: a driver queues hand-computed results per command,
// a monitor pops and compares them each time the controller finishes a command.
module tb_rpn_stack_ctrl;
  import rpn_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int LM    = WIDTH + 1;

  typedef struct packed {
    logic [7:0] dout;
    logic       dval;
    logic [3:0] depth;
    logic       under;
    logic       full;
    logic       ovf;
    logic [7:0] lat;
  } obs_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
    obs_t       exp;
  } vec_t;

  logic              clk;
  logic              reset;
  logic signed [7:0] dout;
  logic              dval;
  logic [3:0]        depth;
  logic              busy;
  logic              err_under;
  logic              err_full;
  logic              err_ovf;

  rpn_stack_ctrl_if #(.WIDTH(WIDTH)) cmd_if ();

  rpn_stack_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd_if),
    .dout      (dout),
    .dval      (dval),
    .depth     (depth),
    .busy      (busy),
    .err_under (err_under),
    .err_full  (err_full),
    .err_ovf   (err_ovf)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int   checks;
  int   errors;
  int   commit_idx;
  int   busy_cnt;
  logic prev_busy;
  obs_t exp_q [$];
  vec_t vecs  [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [7:0] data, input logic [7:0] d,
                              input logic v, input logic [3:0] dep, input logic u,
                              input logic f, input logic o, input int lat);
    vec_t r;
    r.op        = op;
    r.data      = data;
    r.exp.dout  = d;
    r.exp.dval  = v;
    r.exp.depth = dep;
    r.exp.under = u;
    r.exp.full  = f;
    r.exp.ovf   = o;
    r.exp.lat   = 8'(lat);
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_dout"},  64'(dout),             64'd0);
    check({tag, "_dval"},  64'(dval),             64'd0);
    check({tag, "_depth"}, 64'(depth),            64'd0);
    check({tag, "_ready"}, 64'(cmd_if.cmd_ready), 64'd1);
    check({tag, "_busy"},  64'(busy),             64'd0);
    check({tag, "_errs"},  64'({err_under, err_full, err_ovf}), 64'd0);
  endtask

  // Waits for ready, queues the expectation (when given) and holds valid for one accept edge.
  task automatic issue(input vec_t v, input bit expect_it);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!cmd_if.cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_if.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got busy after %0d cycles expected ready", waited);
      return;
    end
    if (expect_it) exp_q.push_back(v.exp);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = v.op;
    cmd_if.cmd_data  = v.data;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Monitor: a busy->ready transition is a commit; busy_cnt is the accept-to-commit latency.
  initial begin : monitor
    obs_t act;
    obs_t exp;
    busy_cnt   = 0;
    prev_busy  = 1'b0;
    commit_idx = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_cnt  = 0;
        prev_busy = 1'b0;
      end else begin
        if (busy) begin
          busy_cnt++;
        end else if (prev_busy) begin
          act.dout  = dout;
          act.dval  = dval;
          act.depth = depth;
          act.under = err_under;
          act.full  = err_full;
          act.ovf   = err_ovf;
          act.lat   = 8'(busy_cnt);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: got %h expected none", act);
          end else begin
            exp = exp_q.pop_front();
            check($sformatf("cmd%0d", commit_idx), 64'(act), 64'(exp));
          end
          commit_idx++;
          busy_cnt = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : stimulus
    int drain;
    checks           = 0;
    errors           = 0;
    reset            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_data  = 8'd0;

    repeat (2) @(negedge clk);
    check_idle("in_reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // op, data, dout, dval, depth, under, full, ovf, latency
    vecs.push_back(mk(OP_PUSH, 8'd2,   8'd2,   1, 4'd1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_PUSH, 8'd5,   8'd5,   1, 4'd2, 0, 0, 0, 1));
    vecs.push_back(mk(OP_ADD,  8'd0,   8'd7,   1, 4'd1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_PUSH, 8'hFD,  8'hFD,  1, 4'd2, 0, 0, 0, 1));
    vecs.push_back(mk(OP_MULT, 8'd0,   8'hEB,  1, 4'd1, 0, 0, 0, LM));
    vecs.push_back(mk(OP_POP,  8'd0,   8'd0,   0, 4'd0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_POP,  8'd0,   8'd0,   0, 4'd0, 1, 0, 0, 1));
    for (int i = 1; i <= 6; i++)
      vecs.push_back(mk(OP_PUSH, 8'(i), 8'(i), 1, 4'(i), 0, 0, 0, 1));
    vecs.push_back(mk(OP_MULT, 8'd0,   8'd30,  1, 4'd5, 0, 0, 0, LM));
    vecs.push_back(mk(OP_MULT, 8'd0,   8'd120, 1, 4'd4, 0, 0, 0, LM));
    vecs.push_back(mk(OP_MULT, 8'd0,   8'd104, 1, 4'd3, 0, 0, 1, LM));
    vecs.push_back(mk(OP_MULT, 8'd0,   8'hD0,  1, 4'd2, 0, 0, 1, LM));
    vecs.push_back(mk(OP_MULT, 8'd0,   8'hD0,  1, 4'd1, 0, 0, 0, LM));
    vecs.push_back(mk(OP_POP,  8'd0,   8'd0,   0, 4'd0, 0, 0, 0, 1));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(OP_PUSH, 8'(10 * i), 8'(10 * i), 1, 4'(i), 0, 0, 0, 1));
    vecs.push_back(mk(OP_PUSH, 8'd90,  8'd80,  1, 4'd8, 0, 1, 0, 1));
    for (int i = 7; i >= 1; i--)
      vecs.push_back(mk(OP_POP, 8'd0, 8'(10 * i), 1, 4'(i), 0, 0, 0, 1));
    vecs.push_back(mk(OP_ADD,  8'd0,   8'd10,  1, 4'd1, 1, 0, 0, 1));
    vecs.push_back(mk(OP_MULT, 8'd0,   8'd10,  1, 4'd1, 1, 0, 0, 1));
    vecs.push_back(mk(OP_POP,  8'd0,   8'd0,   0, 4'd0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_PUSH, 8'd100, 8'd100, 1, 4'd1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_PUSH, 8'd100, 8'd100, 1, 4'd2, 0, 0, 0, 1));
    vecs.push_back(mk(OP_ADD,  8'd0,   8'hC8,  1, 4'd1, 0, 0, 1, 1));
    vecs.push_back(mk(OP_PUSH, 8'h9C,  8'h9C,  1, 4'd2, 0, 0, 0, 1));
    vecs.push_back(mk(OP_ADD,  8'd0,   8'd100, 1, 4'd1, 0, 0, 1, 1));
    vecs.push_back(mk(OP_PUSH, 8'h80,  8'h80,  1, 4'd2, 0, 0, 0, 1));
    vecs.push_back(mk(OP_MULT, 8'd0,   8'h00,  1, 4'd1, 0, 0, 1, LM));
    vecs.push_back(mk(OP_POP,  8'd0,   8'd0,   0, 4'd0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_PUSH, 8'hFF,  8'hFF,  1, 4'd1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_PUSH, 8'h80,  8'h80,  1, 4'd2, 0, 0, 0, 1));
    vecs.push_back(mk(OP_MULT, 8'd0,   8'h80,  1, 4'd1, 0, 0, 1, LM));
    vecs.push_back(mk(OP_PUSH, 8'hFF,  8'hFF,  1, 4'd2, 0, 0, 0, 1));
    vecs.push_back(mk(OP_POP,  8'd0,   8'h80,  1, 4'd1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_POP,  8'd0,   8'd0,   0, 4'd0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_PUSH, 8'hFF,  8'hFF,  1, 4'd1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_PUSH, 8'hFF,  8'hFF,  1, 4'd2, 0, 0, 0, 1));
    vecs.push_back(mk(OP_MULT, 8'd0,   8'd1,   1, 4'd1, 0, 0, 0, LM));
    vecs.push_back(mk(OP_PUSH, 8'd3,   8'd3,   1, 4'd2, 0, 0, 0, 1));
    vecs.push_back(mk(OP_PUSH, 8'd7,   8'd7,   1, 4'd3, 0, 0, 0, 1));

    foreach (vecs[i]) issue(vecs[i], 1'b1);

    // Abandon a MULT three cycles in; nothing from it may ever commit.
    issue(mk(OP_MULT, 8'd0, 8'd0, 0, 4'd0, 0, 0, 0, 0), 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("mul_abort");
    check("mul_abort_queue", 64'(exp_q.size()), 64'd0);

    issue(mk(OP_PUSH, 8'd4, 8'd4, 1, 4'd1, 0, 0, 0, 1), 1'b1);

    drain = 0;
    while (exp_q.size() != 0 && drain < 100) begin
      @(negedge clk);
      drain++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
